// File: rtl/regfile_load_scheduler_pkg.sv
// Shared FSM encodings and default sizing for regfile_load_scheduler.
// REGSCHED_ONEHOT_W(aw) is the one-hot decode width reachable by an aw-bit row address.
`ifndef REGSCHED_ONEHOT_W
`define REGSCHED_ONEHOT_W(aw) (1 << (aw))
`endif

package regfile_load_scheduler_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 13;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_ROWS   = `REGSCHED_ONEHOT_W(DEF_ADDR_W);

endpackage

// File: rtl/regfile_load_scheduler_if.sv
// Request bundle for the two write requesters (append port A, addressed port B).
import regfile_load_scheduler_pkg::*;

interface regfile_load_scheduler_if #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              A_Valid;
  logic [DATA_W-1:0] A_Data;
  logic              A_Ready;
  logic              B_Valid;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_Data;
  logic              B_Ready;

  modport master (
    output A_Valid, A_Data, B_Valid, B_Addr, B_Data,
    input  A_Ready, B_Ready
  );

  modport slave (
    input  A_Valid, A_Data, B_Valid, B_Addr, B_Data,
    output A_Ready, B_Ready
  );
endinterface

// File: rtl/regfile_load_scheduler_arb.sv
// Two-requester round-robin arbiter; bit 0 is port A, bit 1 is port B.
// The priority pointer only moves when a granted request actually transfers.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] xfer,
  output logic [1:0] grant
);
  logic prio_b;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio_b ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prio_b <= 1'b0;
    else if (xfer[0]) prio_b <= 1'b1;
    else if (xfer[1]) prio_b <= 1'b0;
  end
endmodule

// File: rtl/regfile_load_scheduler.sv
// Write sequencer for a bank of register rows: append port A, addressed port B, clear sweep.
// Define REGSCHED_FULL_STOP_EN to stall the appender once every row has been appended.
import regfile_load_scheduler_pkg::*;

module regfile_load_scheduler #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  Clock,
  input  logic                  CLRN,
  regfile_load_scheduler_if.slave bus,
  input  logic                  Clear_Req,
  output logic [DATA_W-1:0]     RowIn,
  output logic [ROWS-1:0]       RowLoad,
  output logic [ADDR_W-1:0]     WrPtr,
  output logic [ADDR_W:0]       Count,
  output logic                  Busy,
  output logic                  Err
);
  localparam logic [ADDR_W:0]   ROWS_C   = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS-1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   sweep_row, sweep_next, wr_ptr_next;
  logic [ADDR_W:0]     count_next;
  logic [DATA_W-1:0]   row_in_next;
  logic [ROWS-1:0]     row_load_next;
  logic                err_next, a_full, open, a_xfer, b_xfer;
  logic [1:0]          req, grant;

  function automatic logic [ROWS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

`ifdef REGSCHED_FULL_STOP_EN
  assign a_full = (Count == ROWS_C);
`else
  assign a_full = 1'b0;
`endif

  // A pending clear wins over both requesters in the same cycle.
  assign open   = (state == ST_IDLE) && !Clear_Req;
  assign req    = {bus.B_Valid & open, bus.A_Valid & open & ~a_full};
  assign a_xfer = bus.A_Valid & grant[0];
  assign b_xfer = bus.B_Valid & grant[1];

  assign bus.A_Ready = grant[0];
  assign bus.B_Ready = grant[1];
  assign Busy        = (state == ST_CLEAR);

  rr_arbiter2 u_arb (
    .clk   (Clock),
    .rst_n (CLRN),
    .req   (req),
    .xfer  ({b_xfer, a_xfer}),
    .grant (grant)
  );

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    sweep_next    = sweep_row;
    wr_ptr_next   = WrPtr;
    count_next    = Count;
    row_in_next   = RowIn;
    row_load_next = '0;
    err_next      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Clear_Req) begin
          state_next    = ST_CLEAR;
          sweep_next    = '0;
          wr_ptr_next   = '0;
          count_next    = '0;
          row_in_next   = '0;
          row_load_next = onehot('0);
        end else if (a_xfer) begin
          row_in_next   = bus.A_Data;
          row_load_next = onehot(WrPtr);
          wr_ptr_next   = (WrPtr == LAST_ROW) ? '0 : WrPtr + 1'b1;
          if (Count != ROWS_C) count_next = Count + 1'b1;
        end else if (b_xfer) begin
          row_in_next = bus.B_Data;
          if ({1'b0, bus.B_Addr} < ROWS_C) row_load_next = onehot(bus.B_Addr);
          else                             err_next      = 1'b1;
        end
      end
      ST_CLEAR: begin
        // Row 0 was loaded on entry, so each CLEAR cycle loads the next row.
        row_in_next = '0;
        if (sweep_row == LAST_ROW) begin
          state_next = ST_IDLE;
        end else begin
          sweep_next    = sweep_row + 1'b1;
          row_load_next = onehot(sweep_row + 1'b1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      sweep_row <= '0;
      WrPtr     <= '0;
      Count     <= '0;
      RowIn     <= '0;
      RowLoad   <= '0;
      Err       <= 1'b0;
    end else begin
      sweep_row <= sweep_next;
      WrPtr     <= wr_ptr_next;
      Count     <= count_next;
      RowIn     <= row_in_next;
      RowLoad   <= row_load_next;
      Err       <= err_next;
    end
  end
endmodule

// File: tb/tb_regfile_load_scheduler.sv
// Scoreboard bench for regfile_load_scheduler: an 8-row instance and a 6-row instance.
module tb_regfile_load_scheduler;
  import regfile_load_scheduler_pkg::*;

  typedef struct packed {
    logic [7:0]  load;
    logic [12:0] data;
    logic        err;
  } exp_t;

`ifdef REGSCHED_FULL_STOP_EN
  localparam bit FULL_STOP = 1'b1;
`else
  localparam bit FULL_STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr8 = 1'b0;
  logic clr6 = 1'b0;
  always #5 clk = ~clk;

  regfile_load_scheduler_if #(.DATA_W(13), .ADDR_W(3)) bus8 ();
  regfile_load_scheduler_if #(.DATA_W(13), .ADDR_W(3)) bus6 ();

  logic [12:0] row_in8, row_in6;
  logic [7:0]  row_load8;
  logic [5:0]  row_load6;
  logic [2:0]  wr_ptr8, wr_ptr6;
  logic [3:0]  count8, count6;
  logic        busy8, busy6, err8, err6;

  regfile_load_scheduler #(.DATA_W(13), .ROWS(8), .ADDR_W(3)) dut8 (
    .Clock(clk), .CLRN(rst_n), .bus(bus8), .Clear_Req(clr8),
    .RowIn(row_in8), .RowLoad(row_load8), .WrPtr(wr_ptr8), .Count(count8),
    .Busy(busy8), .Err(err8)
  );

  regfile_load_scheduler #(.DATA_W(13), .ROWS(6), .ADDR_W(3)) dut6 (
    .Clock(clk), .CLRN(rst_n), .bus(bus6), .Clear_Req(clr6),
    .RowIn(row_in6), .RowLoad(row_load6), .WrPtr(wr_ptr6), .Count(count6),
    .Busy(busy6), .Err(err6)
  );

  int n_pass = 0;
  int n_total = 0;
  exp_t sb[$];
  exp_t sb6[$];
  exp_t e;

  // Reference model of the 8-row instance
  int          m_wp = 0;
  int          m_cnt = 0;
  bit          m_prio_b = 1'b0;
  logic [12:0] m_in = '0;

  function automatic exp_t model_a(input logic [12:0] d);
    exp_t r;
    r.load = 8'(1 << m_wp);
    r.data = d;
    r.err  = 1'b0;
    m_in = d;
    m_wp = (m_wp + 1) % 8;
    if (m_cnt < 8) m_cnt++;
    m_prio_b = 1'b1;
    return r;
  endfunction

  function automatic exp_t model_b(input int addr, input logic [12:0] d);
    exp_t r;
    r.load = 8'(1 << addr);
    r.data = d;
    r.err  = 1'b0;
    m_in = d;
    m_prio_b = 1'b0;
    return r;
  endfunction

  function automatic exp_t model_idle();
    exp_t r;
    r.load = 8'h00;
    r.data = m_in;
    r.err  = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic av, input logic [12:0] ad, input logic bv,
                        input logic [2:0] ba, input logic [12:0] bd, input logic clr);
    bus8.A_Valid = av;
    bus8.A_Data  = ad;
    bus8.B_Valid = bv;
    bus8.B_Addr  = ba;
    bus8.B_Data  = bd;
    clr8         = clr;
    #1;
  endtask

  task automatic idle6();
    bus6.A_Valid = 1'b0;
    bus6.A_Data  = '0;
    bus6.B_Valid = 1'b0;
    bus6.B_Addr  = '0;
    bus6.B_Data  = '0;
    clr6         = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle6();
    drive8(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    m_wp = 0; m_cnt = 0; m_prio_b = 1'b0; m_in = '0;
    sb.delete();
    sb6.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle6();
    drive8(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({row_load8, row_in8, err8, wr_ptr8, count8, busy8} !== 30'd0)
      $display("[TB] FAIL reset_outputs8: got %h_%h_%b_%h_%h_%b want all zero",
               row_load8, row_in8, err8, wr_ptr8, count8, busy8);
    else n_pass++;
    n_total++;
    if ({row_load6, row_in6, err6, wr_ptr6, count6, busy6} !== 28'd0)
      $display("[TB] FAIL reset_outputs6: got %h_%h_%b_%h_%h_%b want all zero",
               row_load6, row_in6, err6, wr_ptr6, count6, busy6);
    else n_pass++;
    n_total++;
    if ({bus8.A_Ready, bus8.B_Ready} !== 2'b00)
      $display("[TB] FAIL reset_ready: got %b want 00", {bus8.A_Ready, bus8.B_Ready});
    else n_pass++;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_append();
    logic [12:0] tbl [3] = '{13'h0011, 13'h0022, 13'h0033};
    for (int i = 0; i < 3; i++) begin
      drive8(1, tbl[i], 0, 0, 0, 0);
      n_total++;
      if (bus8.A_Ready !== 1'b1) $display("[TB] FAIL append_ready[%0d]: got %b want 1", i, bus8.A_Ready);
      else n_pass++;
      sb.push_back(model_a(tbl[i]));
      tick();
      e = sb.pop_front();
      n_total++;
      if ({row_load8, row_in8, err8} !== e)
        $display("[TB] FAIL append_out[%0d]: got %h_%h_%b want %h_%h_%b", i, row_load8, row_in8, err8, e.load, e.data, e.err);
      else n_pass++;
    end
    drive8(0, 0, 0, 0, 0, 0);
    sb.push_back(model_idle());
    tick();
    e = sb.pop_front();
    n_total++;
    if ({row_load8, row_in8, err8} !== e)
      $display("[TB] FAIL append_idle: got %h_%h_%b want %h_%h_%b", row_load8, row_in8, err8, e.load, e.data, e.err);
    else n_pass++;
    n_total++;
    if ({wr_ptr8, count8} !== {3'(m_wp), 4'(m_cnt)})
      $display("[TB] FAIL append_ptr_count: got %0d/%0d want %0d/%0d", wr_ptr8, count8, m_wp, m_cnt);
    else n_pass++;
  endtask

  task automatic test_contention();
    bit exp_a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_a = !m_prio_b;
      drive8(1, 13'(13'h100 + i), 1, 3'd5, 13'(13'h200 + i), 0);
      n_total++;
      if ({bus8.A_Ready, bus8.B_Ready} !== {exp_a, !exp_a})
        $display("[TB] FAIL contention_grant[%0d]: got %b want %b", i, {bus8.A_Ready, bus8.B_Ready}, {exp_a, !exp_a});
      else n_pass++;
      sb.push_back(exp_a ? model_a(13'(13'h100 + i)) : model_b(5, 13'(13'h200 + i)));
      tick();
      e = sb.pop_front();
      n_total++;
      if ({row_load8, row_in8, err8} !== e)
        $display("[TB] FAIL contention_out[%0d]: got %h_%h_%b want %h_%h_%b", i, row_load8, row_in8, err8, e.load, e.data, e.err);
      else n_pass++;
    end
    drive8(0, 0, 0, 0, 0, 0);
    tick();
    n_total++;
    if ({wr_ptr8, count8} !== {3'(m_wp), 4'(m_cnt)})
      $display("[TB] FAIL contention_ptr_count: got %0d/%0d want %0d/%0d", wr_ptr8, count8, m_wp, m_cnt);
    else n_pass++;
  endtask

  task automatic test_clear();
    drive8(1, 13'h1ABC, 0, 0, 0, 1);
    n_total++;
    if ({bus8.A_Ready, bus8.B_Ready} !== 2'b00)
      $display("[TB] FAIL clear_beats_a: got %b want 00", {bus8.A_Ready, bus8.B_Ready});
    else n_pass++;
    for (int k = 0; k < 8; k++) sb.push_back('{8'(1 << k), 13'h0000, 1'b0});
    m_wp = 0; m_cnt = 0; m_in = '0;
    tick();
    for (int k = 0; k < 8; k++) begin
      e = sb.pop_front();
      n_total++;
      if ({row_load8, row_in8, err8, busy8} !== {e, 1'b1})
        $display("[TB] FAIL clear_row[%0d]: got %h_%h_%b busy %b want %h_%h_%b busy 1",
                 k, row_load8, row_in8, err8, busy8, e.load, e.data, e.err);
      else n_pass++;
      if (k < 2) begin
        drive8(1, 13'h0FFF, 1, 3'd1, 13'h0FFF, 1);
        n_total++;
        if ({bus8.A_Ready, bus8.B_Ready} !== 2'b00)
          $display("[TB] FAIL clear_ready[%0d]: got %b want 00", k, {bus8.A_Ready, bus8.B_Ready});
        else n_pass++;
      end else begin
        drive8(0, 0, 0, 0, 0, 0);
      end
      tick();
    end
    sb.push_back(model_idle());
    e = sb.pop_front();
    n_total++;
    if ({row_load8, row_in8, err8, busy8, wr_ptr8, count8} !== {e, 1'b0, 3'd0, 4'd0})
      $display("[TB] FAIL clear_done: got %h_%h_%b busy %b ptr %0d cnt %0d want %h_%h_%b busy 0 ptr 0 cnt 0",
               row_load8, row_in8, err8, busy8, wr_ptr8, count8, e.load, e.data, e.err);
    else n_pass++;
    drive8(1, 13'h0055, 0, 0, 0, 0);
    n_total++;
    if (bus8.A_Ready !== 1'b1) $display("[TB] FAIL clear_first_idle_ready: got %b want 1", bus8.A_Ready);
    else n_pass++;
    sb.push_back(model_a(13'h0055));
    tick();
    e = sb.pop_front();
    n_total++;
    if ({row_load8, row_in8, err8} !== e)
      $display("[TB] FAIL clear_first_append: got %h_%h_%b want %h_%h_%b", row_load8, row_in8, err8, e.load, e.data, e.err);
    else n_pass++;
    drive8(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    bit a_can, ga;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      a_can = !(FULL_STOP && m_cnt == 8);
      drive8(1, 13'(13'h300 + i), 0, 0, 0, 0);
      n_total++;
      if (bus8.A_Ready !== a_can) $display("[TB] FAIL wrap_ready[%0d]: got %b want %b", i, bus8.A_Ready, a_can);
      else n_pass++;
      sb.push_back(a_can ? model_a(13'(13'h300 + i)) : model_idle());
      tick();
      e = sb.pop_front();
      n_total++;
      if ({row_load8, row_in8, err8} !== e)
        $display("[TB] FAIL wrap_out[%0d]: got %h_%h_%b want %h_%h_%b", i, row_load8, row_in8, err8, e.load, e.data, e.err);
      else n_pass++;
    end
    n_total++;
    if ({wr_ptr8, count8} !== {3'(m_wp), 4'(m_cnt)})
      $display("[TB] FAIL wrap_ptr_count: got %0d/%0d want %0d/%0d", wr_ptr8, count8, m_wp, m_cnt);
    else n_pass++;
    a_can = !(FULL_STOP && m_cnt == 8);
    ga = a_can && !m_prio_b;
    drive8(1, 13'h0444, 1, 3'd2, 13'h0555, 0);
    n_total++;
    if ({bus8.A_Ready, bus8.B_Ready} !== {ga, !ga})
      $display("[TB] FAIL wrap_b_grant: got %b want %b", {bus8.A_Ready, bus8.B_Ready}, {ga, !ga});
    else n_pass++;
    sb.push_back(ga ? model_a(13'h0444) : model_b(2, 13'h0555));
    tick();
    e = sb.pop_front();
    n_total++;
    if ({row_load8, row_in8, err8} !== e)
      $display("[TB] FAIL wrap_b_out: got %h_%h_%b want %h_%h_%b", row_load8, row_in8, err8, e.load, e.data, e.err);
    else n_pass++;
    drive8(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_bad_addr();
    int          addrs [4] = '{7, 5, 6, 0};
    logic [12:0] m6_in = '0;
    exp_t        r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle6();
      bus6.B_Valid = 1'b1;
      bus6.B_Addr  = 3'(addrs[i]);
      bus6.B_Data  = 13'(13'h0A0 + i);
      #1;
      n_total++;
      if ({bus6.A_Ready, bus6.B_Ready} !== 2'b01)
        $display("[TB] FAIL bad_addr_ready[%0d]: got %b want 01", i, {bus6.A_Ready, bus6.B_Ready});
      else n_pass++;
      r.load = (addrs[i] < 6) ? 8'(1 << addrs[i]) : 8'h00;
      r.err  = (addrs[i] >= 6);
      r.data = 13'(13'h0A0 + i);
      sb6.push_back(r);
      tick();
      e = sb6.pop_front();
      n_total++;
      if ({2'b00, row_load6, err6} !== {e.load, e.err} || (!e.err && row_in6 !== e.data))
        $display("[TB] FAIL bad_addr_out[%0d]: got %h_%h_%b want %h_%h_%b", i, row_load6, row_in6, err6, e.load, e.data, e.err);
      else n_pass++;
      if (!e.err) m6_in = e.data;
    end
    idle6();
    tick();
    n_total++;
    if ({row_load6, err6, wr_ptr6, count6} !== 14'd0)
      $display("[TB] FAIL bad_addr_idle: got %h_%b ptr %0d cnt %0d want 00_0 ptr 0 cnt 0", row_load6, err6, wr_ptr6, count6);
    else n_pass++;
    n_total++;
    if (row_in6 !== m6_in) $display("[TB] FAIL bad_addr_hold: got %h want %h", row_in6, m6_in);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    drive8(1, 13'h0123, 0, 0, 0, 0);
    sb.push_back(model_a(13'h0123));
    tick();
    e = sb.pop_front();
    drive8(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) sb.push_back('{8'(1 << k), 13'h0000, 1'b0});
    tick();
    drive8(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      n_total++;
      if ({row_load8, row_in8, err8} !== e)
        $display("[TB] FAIL sweep_before_reset[%0d]: got %h_%h_%b want %h_%h_%b", k, row_load8, row_in8, err8, e.load, e.data, e.err);
      else n_pass++;
      if (k < 3) tick();
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({row_load8, row_in8, err8, wr_ptr8, count8, busy8} !== 30'd0)
      $display("[TB] FAIL mid_sweep_reset: got %h_%h_%b_%h_%h_%b want all zero",
               row_load8, row_in8, err8, wr_ptr8, count8, busy8);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    tick();
    m_wp = 0; m_cnt = 0; m_prio_b = 1'b0; m_in = '0;
    drive8(1, 13'h0077, 0, 0, 0, 0);
    n_total++;
    if (bus8.A_Ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %b want 1", bus8.A_Ready);
    else n_pass++;
    sb.push_back(model_a(13'h0077));
    tick();
    drive8(0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_total++;
    if ({row_load8, row_in8, err8, busy8} !== {e, 1'b0})
      $display("[TB] FAIL post_reset_append: got %h_%h_%b busy %b want %h_%h_%b busy 0",
               row_load8, row_in8, err8, busy8, e.load, e.data, e.err);
    else n_pass++;
  endtask

  initial begin
    $display("[TB] start, full stop build = %0d", FULL_STOP);
    test_reset();
    test_append();
    test_contention();
    test_clear();
    test_wrap();
    test_bad_addr();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
